// File: rtl/io_pin_bank_pkg.sv
// io_pin_bank shared package: settings-bus
// register addresses, pin width and masked-write helper.
package io_pin_pkg;

  localparam int WIDTH = 16;
  localparam int NBANK = 4;

  localparam logic [6:0] FR_OE_0 = 7'd5;
  localparam logic [6:0] FR_OE_1 = 7'd6;
  localparam logic [6:0] FR_OE_2 = 7'd7;
  localparam logic [6:0] FR_OE_3 = 7'd8;
  localparam logic [6:0] FR_IO_0 = 7'd9;
  localparam logic [6:0] FR_IO_1 = 7'd10;
  localparam logic [6:0] FR_IO_2 = 7'd11;
  localparam logic [6:0] FR_IO_3 = 7'd12;

  typedef logic [WIDTH-1:0] pin_t;

  // Settings word layout: mask in the
  // upper half, value in the lower half.
  typedef struct packed {
    pin_t mask;
    pin_t value;
  } wr_t;

  function automatic pin_t masked_merge(
    input pin_t cur,
    input wr_t  wr
  );
    return (cur & ~wr.mask)
         | (wr.value & wr.mask);
  endfunction

endpackage

// File: rtl/io_pin_bank_if.sv
// io_pin_bank serial settings bus:
// one-cycle strobe, 7-bit address, 32-bit data.
interface io_pin_bank_if;

  logic        serial_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;

  modport master (
    output serial_strobe,
    output serial_addr,
    output serial_data
  );

  modport slave (
    input serial_strobe,
    input serial_addr,
    input serial_data
  );

endinterface

// File: rtl/io_pin_bank_masked_reg.sv
// io_pin_bank masked_reg: one 16-bit settings
// register updated by masked writes at ADDR.
import io_pin_pkg::*;

module masked_reg #(
  parameter logic [6:0] ADDR = 7'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        strobe,
  input  logic [6:0]  addr,
  input  logic [31:0] data,
  output pin_t        q
);

  logic hit;
  wr_t  wr;

  assign hit = strobe && (addr == ADDR);
  assign wr  = wr_t'(data);

  // Merge masked value bits on an address hit;
  // reset wins over a coincident strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (hit) begin
      q <= masked_merge(q, wr);
    end
  end

endmodule

// File: rtl/io_pin_bank.sv
// io_pin_bank top: four 16-bit GPIO banks with OE/out
// registers, tri-state drive and pin readback.
// Build option IO_SYNC_EN: two-flop pin synchroniser
// ahead of readback (3-clock pin-to-readback latency).
import io_pin_pkg::*;

module io_pin_bank (
  input  logic              clock,
  input  logic              reset,
  io_pin_bank_if.slave      serial,
  inout  wire [WIDTH-1:0]   io_0,
  inout  wire [WIDTH-1:0]   io_1,
  inout  wire [WIDTH-1:0]   io_2,
  inout  wire [WIDTH-1:0]   io_3,
  output logic [31:0]       readback_0,
  output logic [31:0]       readback_1
);

  pin_t oe      [NBANK];
  pin_t out     [NBANK];
  pin_t pins    [NBANK];
  pin_t sampled [NBANK];

  for (genvar n = 0; n < NBANK; n++) begin : g_bank
    masked_reg #(
      .ADDR(FR_OE_0 + 7'(n))
    ) u_oe (
      .clock  (clock),
      .reset  (reset),
      .strobe (serial.serial_strobe),
      .addr   (serial.serial_addr),
      .data   (serial.serial_data),
      .q      (oe[n])
    );

    masked_reg #(
      .ADDR(FR_IO_0 + 7'(n))
    ) u_out (
      .clock  (clock),
      .reset  (reset),
      .strobe (serial.serial_strobe),
      .addr   (serial.serial_addr),
      .data   (serial.serial_data),
      .q      (out[n])
    );
  end

  // Each pin is driven only while its OE bit
  // is set; otherwise it floats for the board.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign io_0[i] = oe[0][i] ? out[0][i] : 1'bz;
    assign io_1[i] = oe[1][i] ? out[1][i] : 1'bz;
    assign io_2[i] = oe[2][i] ? out[2][i] : 1'bz;
    assign io_3[i] = oe[3][i] ? out[3][i] : 1'bz;
  end

  assign pins[0] = io_0;
  assign pins[1] = io_1;
  assign pins[2] = io_2;
  assign pins[3] = io_3;

`ifdef IO_SYNC_EN
  pin_t sync_a [NBANK];
  pin_t sync_b [NBANK];

  // Two-flop synchroniser for asynchronous
  // external inputs before they reach readback.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < NBANK; n++) begin
        sync_a[n] <= '0;
        sync_b[n] <= '0;
      end
    end else begin
      sync_a <= pins;
      sync_b <= sync_a;
    end
  end

  assign sampled = sync_b;
`else
  assign sampled = pins;
`endif

  // Readback register: pin state packed
  // two banks per 32-bit word.
  always_ff @(posedge clock) begin
    if (reset) begin
      readback_0 <= '0;
      readback_1 <= '0;
    end else begin
      readback_0 <= {sampled[1], sampled[0]};
      readback_1 <= {sampled[3], sampled[2]};
    end
  end

endmodule

// File: tb/tb_io_pin_bank.sv
// io_pin_bank bench: directed and random settings
// writes against a register-level model plus scoreboard.
module tb_io_pin_bank;

`ifdef IO_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  io_pin_bank_if serial ();

  wire  [15:0] io_0, io_1, io_2, io_3;
  logic [31:0] readback_0, readback_1;

  logic [15:0] ext_en  [4];
  logic [15:0] ext_val [4];

  io_pin_bank dut (
    .clock      (clock),
    .reset      (reset),
    .serial     (serial.slave),
    .io_0       (io_0),
    .io_1       (io_1),
    .io_2       (io_2),
    .io_3       (io_3),
    .readback_0 (readback_0),
    .readback_1 (readback_1)
  );

  // External board: drives only pins the DUT floats.
  for (genvar i = 0; i < 16; i++) begin : g_ext
    assign io_0[i] = ext_en[0][i] ? ext_val[0][i] : 1'bz;
    assign io_1[i] = ext_en[1][i] ? ext_val[1][i] : 1'bz;
    assign io_2[i] = ext_en[2][i] ? ext_val[2][i] : 1'bz;
    assign io_3[i] = ext_en[3][i] ? ext_val[3][i] : 1'bz;
  end

  logic [15:0] m_oe  [4];
  logic [15:0] m_out [4];

  typedef struct {
    int          due;
    logic [31:0] rb0;
    logic [31:0] rb1;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] pin_expect(int b);
    return (m_oe[b] & m_out[b]) | (~m_oe[b] & ext_val[b]);
  endfunction

  function automatic logic [15:0] pin_now(int b);
    case (b)
      0: return io_0;
      1: return io_1;
      2: return io_2;
      default: return io_3;
    endcase
  endfunction

  // Scoreboard monitor: readback is presented every
  // cycle; compare whatever is due on this cycle.
  always @(negedge clock) begin
    #2;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due != cyc) begin
        compared++;
        mismatched++;
        $display("FAIL stale_entry due=%0d cyc=%0d",
                 e.due, cyc);
      end else begin
        check("readback_0", readback_0, e.rb0);
        check("readback_1", readback_1, e.rb1);
      end
    end
  end

  // One clock of stimulus, entered just after a negedge.
  task automatic step(
    input logic        stb,
    input logic [6:0]  a,
    input logic [31:0] d
  );
    logic [15:0] mask, val;
    int unsigned ua;
    for (int b = 0; b < 4; b++) ext_en[b] = ~m_oe[b];
    #1;
    for (int b = 0; b < 4; b++)
      check($sformatf("pin_%0d", b),
            32'(pin_now(b)), 32'(pin_expect(b)));
    if (!reset)
      q.push_back('{cyc + LAT,
        {pin_expect(1), pin_expect(0)},
        {pin_expect(3), pin_expect(2)}});
    serial.serial_strobe = stb;
    serial.serial_addr   = a;
    serial.serial_data   = d;
    mask = d[31:16];
    val  = d[15:0];
    ua   = 32'(a);
    if (reset) begin
      for (int b = 0; b < 4; b++) begin
        m_oe[b]  = '0;
        m_out[b] = '0;
      end
    end else if (stb) begin
      if (ua >= 5 && ua <= 8)
        m_oe[ua-5] = (m_oe[ua-5] & ~mask) | (val & mask);
      else if (ua >= 9 && ua <= 12)
        m_out[ua-9] = (m_out[ua-9] & ~mask) | (val & mask);
    end
    @(posedge clock);
    #1;
    serial.serial_strobe = 1'b0;
    for (int b = 0; b < 4; b++) ext_en[b] = ~m_oe[b];
    @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    #3;
    q.delete();
    reset = 1'b1;
    for (int k = 0; k < n; k++)
      step(1'b1, 7'($urandom_range(5, 12)), $urandom);
    reset = 1'b0;
    #1;
    check("reset_rb0", readback_0, 32'h0);
    check("reset_rb1", readback_1, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 7'd0, 32'h0);
  endtask

  task automatic rand_ext();
    for (int b = 0; b < 4; b++) ext_val[b] = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    serial.serial_strobe = 1'b0;
    serial.serial_addr   = '0;
    serial.serial_data   = '0;
    for (int b = 0; b < 4; b++) begin
      m_oe[b]    = '0;
      m_out[b]   = '0;
      ext_en[b]  = '1;
      ext_val[b] = '0;
    end
    @(negedge clock);
    rand_ext();
    do_reset(3);

    // Bank 0 low byte driven, high byte from board.
    ext_val[0] = 16'h3C00;
    step(1'b1, 7'd5, 32'hFFFF_00FF);
    step(1'b1, 7'd9, 32'hFFFF_A5A5);
    idle(LAT + 1);
    #1 check("io_0_3CA5", 32'(io_0), 32'h3CA5);
    #1 check("rb0_3CA5", readback_0 & 32'hFFFF, 32'h3CA5);

    step(1'b1, 7'd9, 32'h000F_0000);
    step(1'b1, 7'd9, 32'h0000_FFFF);
    step(1'b1, 7'd5, 32'hFFFF_FFFF);
    #1 check("out_0_A5A0", 32'(io_0), 32'hA5A0);
    idle(1);

    step(1'b1, 7'd8, 32'hFFFF_FFFF);
    step(1'b1, 7'd12, 32'hFFFF_1234);
    idle(LAT + 1);
    #1 check("io_3_1234", 32'(io_3), 32'h1234);
    #1 check("rb1_1234", readback_1 >> 16, 32'h1234);

    // Out-of-range addresses must not touch anything.
    rand_ext();
    step(1'b1, 7'd13, 32'hFFFF_FFFF);
    step(1'b1, 7'd4, 32'hFFFF_FFFF);
    step(1'b1, 7'd0, 32'hFFFF_5555);
    step(1'b1, 7'd127, 32'hFFFF_AAAA);
    idle(2);

    // Back-to-back writes to two different banks.
    step(1'b1, 7'd6, 32'hFFFF_FFFF);
    step(1'b1, 7'd10, 32'hFFFF_BEEF);
    #1 check("io_1_BEEF", 32'(io_1), 32'hBEEF);
    idle(LAT + 1);

    // Mid-operation reset with coincident strobes.
    do_reset(1);
    idle(2);

    for (int k = 0; k < 600; k++) begin
      rand_ext();
      if ($urandom_range(0, 60) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        step($urandom_range(0, 3) != 0,
             7'($urandom_range(3, 14)),
             $urandom);
      end
    end
    idle(LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
